// File: rtl/turn_pkg.sv
// Shared types and defaults for the game-turn sequencer.
// Imported by the turn controller and its prescaler.
package turn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    AUTO = 2'd2,
    DONE = 2'd3
  } turn_state_t;

  localparam int DEF_CLOCK_FREQ   = 100_000_000;
  localparam int DEF_TURN_SECONDS = 15;

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts clk cycles and flags the last
// cycle of each second; clr restarts the second from zero.
module sec_prescaler #(
  parameter int CLOCK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_FREQ - 1);

  logic [CW-1:0] cnt;

  // cycle counter, wraps at the end of each second
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/turn_controller.sv
// Turn sequencer: per-turn deadline countdown, player toggle
// and forced-move request toward the board logic.
module turn_controller
  import turn_pkg::*;
#(
  parameter int CLOCK_FREQ   = DEF_CLOCK_FREQ,
  parameter int TURN_SECONDS = DEF_TURN_SECONDS,
  parameter int SW           = $clog2(TURN_SECONDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          move_valid,
  input  logic          game_over,
  input  logic          auto_move_ack,
  output logic          auto_move_req,
  output logic          player,
  output logic [SW-1:0] secs_left,
  output logic [1:0]    state
);

  localparam logic [SW-1:0] FULL = SW'(TURN_SECONDS);
  localparam logic [SW-1:0] ONE  = SW'(1);

  turn_state_t   state_q, state_d;
  logic          player_q, player_d;
  logic [SW-1:0] secs_q, secs_d;
  logic          req_q, req_d;
  logic          pre_en, pre_clr, tick;

  sec_prescaler #(
    .CLOCK_FREQ(CLOCK_FREQ)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tick(tick)
  );

  // state and turn registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      player_q <= 1'b0;
      secs_q   <= FULL;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      secs_q   <= secs_d;
      req_q    <= req_d;
    end
  end

  // next state: game_over > start > move/ack > tick
  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    secs_d   = secs_q;
    req_d    = req_q;
    pre_en   = 1'b0;
    pre_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        player_d = 1'b0;
        secs_d   = FULL;
        pre_clr  = 1'b1;
        if (start) state_d = PLAY;
      end
      PLAY: begin
        pre_en = 1'b1;
        if (game_over) begin
          state_d = DONE;
          req_d   = 1'b0;
          pre_en  = 1'b0;
        end else if (start) begin
          player_d = 1'b0;
          secs_d   = FULL;
          pre_clr  = 1'b1;
        end else if (move_valid) begin
          player_d = ~player_q;
          secs_d   = FULL;
          pre_clr  = 1'b1;
        end else if (tick) begin
          if (secs_q > ONE) begin
            secs_d = secs_q - ONE;
          end else begin
            secs_d  = '0;
            state_d = AUTO;
            req_d   = 1'b1;
          end
        end
      end
      AUTO: begin
        req_d = 1'b1;
        if (game_over) begin
          state_d = DONE;
          req_d   = 1'b0;
        end else if (start) begin
          state_d  = PLAY;
          player_d = 1'b0;
          secs_d   = FULL;
          req_d    = 1'b0;
          pre_clr  = 1'b1;
        end else if (auto_move_ack) begin
          state_d  = PLAY;
          player_d = ~player_q;
          secs_d   = FULL;
          req_d    = 1'b0;
          pre_clr  = 1'b1;
        end
      end
      DONE: begin
        req_d   = 1'b0;
        pre_clr = 1'b1;
        if (start) begin
          state_d  = PLAY;
          player_d = 1'b0;
          secs_d   = FULL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign auto_move_req = req_q;
  assign player        = player_q;
  assign secs_left     = secs_q;
  assign state         = state_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller at CLOCK_FREQ=4, TURN_SECONDS=3.
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, move_valid, game_over, auto_move_ack;
  logic       auto_move_req, player;
  logic [1:0] secs_left;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         n;
    logic       st, mv, go, ack;
    logic [1:0] es;
    logic       ep;
    logic [1:0] esec;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  turn_controller #(
    .CLOCK_FREQ  (4),
    .TURN_SECONDS(3),
    .SW          (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .move_valid   (move_valid),
    .game_over    (game_over),
    .auto_move_ack(auto_move_ack),
    .auto_move_req(auto_move_req),
    .player       (player),
    .secs_left    (secs_left),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int es, input int ep,
                         input int esec, input int er);
    chk({nm, ".state"}, int'(state), es);
    chk({nm, ".player"}, int'(player), ep);
    chk({nm, ".secs"}, int'(secs_left), esec);
    chk({nm, ".req"}, int'(auto_move_req), er);
  endtask

  function automatic void add(input int n, input logic st, input logic mv,
                              input logic go, input logic ack,
                              input logic [1:0] es, input logic ep,
                              input logic [1:0] esec, input logic er);
    vec_t v;
    v.n = n; v.st = st; v.mv = mv; v.go = go; v.ack = ack;
    v.es = es; v.ep = ep; v.esec = esec; v.er = er;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic st, input logic mv,
                       input logic go, input logic ack);
    start = st; move_valid = mv; game_over = go; auto_move_ack = ack;
  endtask

  initial begin
    // n, start, move, over, ack -> state, player, secs, req
    // full turn, AUTO, ignored move, ack
    add(1, 1, 0, 0, 0, 1, 0, 3, 0);
    add(3, 0, 0, 0, 0, 1, 0, 3, 0);
    add(4, 0, 0, 0, 0, 1, 0, 2, 0);
    add(4, 0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 2, 0, 0, 1);
    add(1, 0, 0, 0, 0, 2, 0, 0, 1);
    add(1, 0, 1, 0, 0, 2, 0, 0, 1);
    add(2, 0, 0, 0, 0, 2, 0, 0, 1);
    add(1, 0, 0, 0, 1, 1, 1, 3, 0);
    // restart, move at cycle 6, AUTO 12 cycles later
    add(1, 1, 0, 0, 0, 1, 0, 3, 0);
    add(3, 0, 0, 0, 0, 1, 0, 3, 0);
    add(2, 0, 0, 0, 0, 1, 0, 2, 0);
    add(1, 0, 1, 0, 0, 1, 1, 3, 0);
    add(3, 0, 0, 0, 0, 1, 1, 3, 0);
    add(4, 0, 0, 0, 0, 1, 1, 2, 0);
    add(4, 0, 0, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 2, 1, 0, 1);
    add(1, 0, 0, 0, 1, 1, 0, 3, 0);
    // move on the final tick wins
    add(3, 0, 0, 0, 0, 1, 0, 3, 0);
    add(4, 0, 0, 0, 0, 1, 0, 2, 0);
    add(4, 0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 0, 1, 0, 0, 1, 1, 3, 0);
    add(3, 0, 0, 0, 0, 1, 1, 3, 0);
    add(4, 0, 0, 0, 0, 1, 1, 2, 0);
    add(4, 0, 0, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 2, 1, 0, 1);
    // game over from AUTO, DONE frozen, restart
    add(1, 0, 0, 1, 0, 3, 1, 0, 0);
    add(1, 0, 1, 1, 0, 3, 1, 0, 0);
    add(1, 0, 0, 1, 1, 3, 1, 0, 0);
    add(1, 0, 1, 0, 0, 3, 1, 0, 0);
    add(1, 0, 0, 0, 1, 3, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 3, 0);
    // ack in PLAY, start vs game_over priority
    add(1, 0, 0, 0, 1, 1, 0, 3, 0);
    add(1, 1, 0, 1, 0, 3, 0, 3, 0);
    add(1, 1, 0, 1, 0, 1, 0, 3, 0);
    add(1, 0, 0, 1, 0, 3, 0, 3, 0);
    add(1, 1, 0, 1, 0, 1, 0, 3, 0);
    add(1, 0, 0, 0, 0, 1, 0, 3, 0);

    // reset and idle
    rst = 1'b0;
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("in_reset", 0, 0, 3, 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("idle%0d", i), 0, 0, 3, 0);
    end

    // vector table
    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        drive(tbl[r].st, tbl[r].mv, tbl[r].go, tbl[r].ack);
        @(posedge clk);
        #1;
        chk_all($sformatf("row%0d.%0d", r, k), int'(tbl[r].es),
                int'(tbl[r].ep), int'(tbl[r].esec), int'(tbl[r].er));
      end
    end
    drive(0, 0, 0, 0);

    // async reset mid-turn with player 1, secs 2
    drive(0, 1, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk_all("pre_rst", 1, 1, 2, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 3, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk_all("rst_held", 0, 0, 3, 0);
    @(posedge clk);
    #1;
    chk_all("post_rst", 0, 0, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
